// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit: operands and decode fields in,
// registered result out, each side with its own valid/ready pair.
interface alu_exec_unit_if #(
  parameter int XLEN = 64
);
  logic            i_valid;
  logic            o_ready;
  logic [1:0]      i_aluop;
  logic            i_funct7_5;
  logic            i_funct7_0;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_zero;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_aluop, i_funct7_5, i_funct7_0, i_funct3, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_zero, o_illegal
  );

  modport master (
    output i_valid, i_aluop, i_funct7_5, i_funct7_0, i_funct3, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_zero, o_illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// RV64 integer execute unit: single-cycle base ALU ops plus iterative unsigned
// MUL/MULHU (shift-add) and DIVU/REMU (restoring), XLEN iterations each.
module alu_exec_unit #(
  parameter int XLEN = 64,
  parameter int CW   = $clog2(XLEN + 1)
) (
  input logic            i_clk,
  input logic            i_rst_n,
  alu_exec_unit_if.slave bus
);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_ILL
  } op_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              md_div_q, md_div_d;
  logic              md_hi_q, md_hi_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  op_e             op;
  logic            is_md;
  logic            ready;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;

  // NOTE: every signal written in an always_comb gets a default first; a path
  // that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    op = OP_ILL;
    case (bus.i_aluop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        if (!bus.i_funct7_0) begin
          case (bus.i_funct3)
            3'b000: op = bus.i_funct7_5 ? OP_SUB : OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: op = bus.i_funct7_5 ? OP_SRA : OP_SRL;
            3'b110: op = OP_OR;
            3'b111: op = OP_AND;
          endcase
        end else begin
          case (bus.i_funct3)
            3'b000:  op = OP_MUL;
            3'b011:  op = OP_MULHU;
            3'b101:  op = OP_DIVU;
            3'b111:  op = OP_REMU;
            default: op = OP_ILL;
          endcase
        end
      end
      default: op = OP_ILL;
    endcase
  end

  assign is_md = (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  assign shamt = bus.i_b[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = bus.i_a + bus.i_b;
      OP_SUB:  alu_res = bus.i_a - bus.i_b;
      OP_SLL:  alu_res = bus.i_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.i_a) < $signed(bus.i_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.i_a < bus.i_b)};
      OP_XOR:  alu_res = bus.i_a ^ bus.i_b;
      OP_SRL:  alu_res = bus.i_a >> shamt;
      OP_SRA:  alu_res = $signed(bus.i_a) >>> shamt;
      OP_OR:   alu_res = bus.i_a | bus.i_b;
      OP_AND:  alu_res = bus.i_a & bus.i_b;
      default: alu_res = '0;
    endcase
  end

  // acc holds {partial product high, multiplier} for MUL, {remainder, quotient} for DIV.
  logic [XLEN-1:0]   mul_add;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] step_acc;

  assign mul_add   = acc_q[0] ? opnd_q : '0;
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[XLEN-1:0] - opnd_q;
  assign step_acc  = md_div_q
                   ? {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge}
                   : {mul_sum, acc_q[XLEN-1:1]};

  assign ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.i_ready);
  assign accept = bus.i_valid && ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    md_div_d  = md_div_q;
    md_hi_d   = md_hi_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;

    case (state_q)
      S_BUSY: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d   = S_DONE;
          cnt_d     = '0;
          result_d  = md_hi_q ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
          zero_d    = (result_d == '0);
          illegal_d = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.i_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // An accept (only possible from IDLE or a consumed DONE) overrides the above.
    if (accept) begin
      if (is_md) begin
        state_d  = S_BUSY;
        cnt_d    = '0;
        md_div_d = (op == OP_DIVU) || (op == OP_REMU);
        md_hi_d  = (op == OP_MULHU) || (op == OP_REMU);
        acc_d    = {{XLEN{1'b0}}, (md_div_d ? bus.i_a : bus.i_b)};
        opnd_d   = md_div_d ? bus.i_b : bus.i_a;
      end else begin
        state_d   = S_DONE;
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        illegal_d = (op == OP_ILL);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge value regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      // NOTE: the datapath registers are cleared too, so no stale accumulator
      // or result survives a reset.
      acc_q     <= '0;
      opnd_q    <= '0;
      md_div_q  <= 1'b0;
      md_hi_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      md_div_q  <= md_div_d;
      md_hi_q   <= md_hi_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid   = (state_q == S_DONE);
  assign bus.o_result  = result_q;
  assign bus.o_zero    = zero_q;
  assign bus.o_illegal = illegal_q;
endmodule
